clkdiv_sched: RTL

- Two-channel programmable clock-divider controller. Each channel generates a divided square-wave output from Clk, with independently programmable low-phase and high-phase lengths.
- New settings are written through a valid/ready configuration port. They take effect only at a period boundary, so the outputs never glitch.
- Sits between the board-level control logic and the slow-clock consumers (display scan, debounce, LED blink).

---
 rtl/clkdiv_pkg.sv | 33 +++
 rtl/clkdiv_channel.sv | 128 ++++++++++++
 rtl/clkdiv_sched.sv | 85 ++++++++
 3 files changed

// File: rtl/clkdiv_pkg.sv
// -----------------------------------------------------------------------------
// clkdiv_pkg
// Shared types for the two-channel clock-divider controller.
//   CNT_W_DEF   : width of phase-length counters and config fields
//   ch_state_t  : per-channel phase state (OFF / LOW / HIGH)
//   ch_cfg_t    : one channel's settings {en, low, high}
//   start_state : phase a channel enters when a period begins under a config
// -----------------------------------------------------------------------------
package clkdiv_pkg;

    localparam int CNT_W_DEF = 13;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } ch_state_t;

    typedef struct packed {
        logic                 en;
        logic [CNT_W_DEF-1:0] low;
        logic [CNT_W_DEF-1:0] high;
    } ch_cfg_t;

    // A zero-length phase is skipped entirely; both zero means nothing to run.
    function automatic ch_state_t start_state(input ch_cfg_t cfg);
        if (!cfg.en)          return OFF;
        if (cfg.low  != '0)   return LOW;
        if (cfg.high != '0)   return HIGH;
        return OFF;
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// -----------------------------------------------------------------------------
// clkdiv_channel
// One divider channel: phase FSM, phase counter, active and shadow config,
// pending flag and period-boundary (wrap) decode.
//   clk_i     : system clock, rising edge
//   rst_i     : asynchronous active-high reset
//   cfg_we_i  : config write strobe (accepted only while ready_o)
//   cfg_i     : new {en, low, high}
//   sync_i    : permission for an OFF channel to start this cycle
//   ready_o   : no config pending, a write will be accepted
//   clk_out_o : registered divided output
//   pend_o    : config accepted, not yet applied
//   wrap_o    : high on the last cycle of each completed period
// -----------------------------------------------------------------------------
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter ch_cfg_t RST_CFG = '0
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    cfg_we_i,
    input  ch_cfg_t cfg_i,
    input  logic    sync_i,
    output logic    ready_o,
    output logic    clk_out_o,
    output logic    pend_o,
    output logic    wrap_o
);

    ch_state_t            state_q, state_d;
    logic [CNT_W_DEF-1:0] cnt_q, cnt_d;
    ch_cfg_t              act_q, act_d;
    ch_cfg_t              shd_q, shd_d;
    ch_cfg_t              nxt_cfg;
    logic                 pend_q, pend_d;
    logic                 clk_out_q;
    logic                 boundary;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        act_d    = act_q;
        shd_d    = shd_q;
        pend_d   = pend_q;
        boundary = 1'b0;
        // The period after a boundary runs on the shadow if one is waiting.
        nxt_cfg  = pend_q ? shd_q : act_q;

        // Accept and apply are mutually exclusive: accept needs !pend_q,
        // apply needs pend_q. A write landing on a boundary waits a period.
        if (cfg_we_i && !pend_q) begin
            shd_d  = cfg_i;
            pend_d = 1'b1;
        end

        case (state_q)
            OFF: begin
                cnt_d = '0;
                if (pend_q && sync_i) begin
                    act_d   = shd_q;
                    pend_d  = 1'b0;
                    state_d = start_state(shd_q);
                end
            end
            LOW: begin
                if (cnt_q == act_q.low - 1'b1) begin
                    cnt_d = '0;
                    // With no high phase the period ends here.
                    if (act_q.high == '0) boundary = 1'b1;
                    else                  state_d  = HIGH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HIGH: begin
                if (cnt_q == act_q.high - 1'b1) begin
                    cnt_d    = '0;
                    boundary = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = OFF;
                cnt_d   = '0;
            end
        endcase

        if (boundary) begin
            if (pend_q) begin
                act_d  = shd_q;
                pend_d = 1'b0;
            end
            state_d = start_state(nxt_cfg);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= start_state(RST_CFG);
            cnt_q     <= '0;
            act_q     <= RST_CFG;
            // NOTE: the shadow is reset as well so a discarded write can never
            // reappear; it is only ever applied while pend_q is set anyway.
            shd_q     <= RST_CFG;
            pend_q    <= 1'b0;
            clk_out_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of every other register.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            act_q     <= act_d;
            shd_q     <= shd_d;
            pend_q    <= pend_d;
            clk_out_q <= (state_d == HIGH);
        end
    end

    assign ready_o   = !pend_q;
    assign pend_o    = pend_q;
    assign clk_out_o = clk_out_q;
    assign wrap_o    = boundary;

endmodule

// File: rtl/clkdiv_sched.sv
// -----------------------------------------------------------------------------
// clkdiv_sched
// Two-channel programmable clock-divider controller. Settings arrive through a
// valid/ready port and take effect only at a period boundary.
//   Clk       : system clock, rising edge
//   Rst       : asynchronous active-high reset
//   cfg_valid : config request
//   cfg_ready : config can be accepted for the channel on cfg_ch
//   cfg_ch    : target channel
//   cfg_en    : channel enable value
//   cfg_low   : low-phase length in Clk cycles
//   cfg_high  : high-phase length in Clk cycles
//   clk_out   : divided outputs, registered
//   pend      : per channel, config accepted but not yet applied
//   wrap      : per channel, pulse on the last cycle of each completed period
// Build option CLKDIV_SYNC_START_EN: channel 1 leaving OFF waits for channel
// 0's next wrap pulse so the two outputs are phase-aligned.
// CNT_W must match clkdiv_pkg::CNT_W_DEF, which sizes the config struct.
// -----------------------------------------------------------------------------
module clkdiv_sched
    import clkdiv_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int RST_LOW  = 600,
    parameter int RST_HIGH = 600
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             cfg_ch,
    input  logic             cfg_en,
    input  logic [CNT_W-1:0] cfg_low,
    input  logic [CNT_W-1:0] cfg_high,
    output logic [1:0]       clk_out,
    output logic [1:0]       pend,
    output logic [1:0]       wrap
);

    localparam ch_cfg_t CH0_RST = '{en: 1'b1,
                                    low: CNT_W_DEF'(RST_LOW),
                                    high: CNT_W_DEF'(RST_HIGH)};

    ch_cfg_t    cfg_in;
    logic [1:0] we;
    logic [1:0] ready;
    logic       sync1;

    assign cfg_in = '{en: cfg_en, low: cfg_low, high: cfg_high};
    assign we[0]  = cfg_valid && (cfg_ch == 1'b0);
    assign we[1]  = cfg_valid && (cfg_ch == 1'b1);

`ifdef CLKDIV_SYNC_START_EN
    assign sync1 = wrap[0];
`else
    assign sync1 = 1'b1;
`endif

    clkdiv_channel #(.RST_CFG(CH0_RST)) u_ch0 (
        .clk_i    (Clk),
        .rst_i    (Rst),
        .cfg_we_i (we[0]),
        .cfg_i    (cfg_in),
        .sync_i   (1'b1),
        .ready_o  (ready[0]),
        .clk_out_o(clk_out[0]),
        .pend_o   (pend[0]),
        .wrap_o   (wrap[0])
    );

    clkdiv_channel #(.RST_CFG('0)) u_ch1 (
        .clk_i    (Clk),
        .rst_i    (Rst),
        .cfg_we_i (we[1]),
        .cfg_i    (cfg_in),
        .sync_i   (sync1),
        .ready_o  (ready[1]),
        .clk_out_o(clk_out[1]),
        .pend_o   (pend[1]),
        .wrap_o   (wrap[1])
    );

    assign cfg_ready = cfg_ch ? ready[1] : ready[0];

endmodule
